// File: rtl/pcie_dll_replay_tx.sv
// PCIe data-link-layer transmit replay engine: buffers every TLP word, forwards it to the link
// through a registered output stage, frees TLPs on ack and replays unacked TLPs on nack/timeout.
module pcie_dll_replay_tx #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 64,
  parameter int MAX_TLP    = 8,
  parameter int TIMEOUT    = 1024,
  parameter int REPLAY_MAX = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_W-1:0]              tlp_data_i,
  input  logic                           tlp_valid_i,
  input  logic                           tlp_last_i,
  output logic                           tlp_ready_o,
  output logic [DATA_W-1:0]              link_data_o,
  output logic                           link_valid_o,
  output logic                           link_last_o,
  input  logic                           link_ready_i,
  input  logic                           ack_i,
  input  logic                           nack_i,
  output logic [$clog2(MAX_TLP+1)-1:0]   unacked_o,
  output logic                           replay_o,
  output logic                           link_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_TLP + 1);
  localparam int QW = (MAX_TLP > 1) ? $clog2(MAX_TLP) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(REPLAY_MAX + 1);

  typedef enum logic [1:0] {
    ST_SEND,
    ST_REWIND,
    ST_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ack_ptr_q, ack_ptr_d;
  logic [QW-1:0]       eq_head_q, eq_head_d, eq_tail_q, eq_tail_d;
  logic [CW-1:0]       tlp_cnt_q, tlp_cnt_d, unacked_q, unacked_d, unacked_after;
  logic [TW-1:0]       timer_q, timer_d;
  logic [RW-1:0]       replay_cnt_q, replay_cnt_d, replay_nxt;
  logic                pend_q, pend_d, mid_q, mid_d;
  logic [DATA_W-1:0]   link_data_q, link_data_d;
  logic                link_valid_q, link_valid_d, link_last_q, link_last_d;

  logic [DATA_W:0]     mem [DEPTH];
  logic [PW-1:0]       end_mem [MAX_TLP];

  logic                full, wr_en, push, ack_take, nack_take, timeout_hit;
  logic                link_accept, stage_free, bypass, fetch;
  logic [DATA_W:0]     fetch_word;

  function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] idx);
    return (idx == QW'(MAX_TLP - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign full        = (wr_ptr_q - ack_ptr_q) == PW'(DEPTH);
  assign tlp_ready_o = !full && (tlp_cnt_q < CW'(MAX_TLP)) && (state_q != ST_ERROR);
  assign wr_en       = tlp_valid_i && tlp_ready_o;
  assign push        = wr_en && tlp_last_i;

  // Ack is applied first; nack and timeout are judged against the post-ack count.
  assign ack_take      = ack_i && (unacked_q != '0) && (state_q != ST_ERROR);
  assign unacked_after = unacked_q - CW'(ack_take);
  assign nack_take     = nack_i && (unacked_after != '0) && (state_q != ST_ERROR);
  assign timeout_hit   = (timer_q == TW'(TIMEOUT - 1)) && (unacked_after != '0) && !ack_take;

  assign link_accept = link_valid_q && link_ready_i;
  assign stage_free  = !link_valid_q || link_ready_i;
  // Cut-through: when nothing is buffered ahead, take the incoming word straight from the input.
  assign bypass      = (rd_ptr_q == wr_ptr_q);
  assign fetch_word  = bypass ? {tlp_last_i, tlp_data_i} : mem[rd_ptr_q[AW-1:0]];
  assign fetch       = (state_q == ST_SEND) && stage_free && (!bypass || wr_en)
                       && (!pend_q || mid_q);
  assign replay_nxt  = replay_cnt_q + 1'b1;

  // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q + PW'(wr_en);
    rd_ptr_d     = rd_ptr_q;
    ack_ptr_d    = ack_ptr_q;
    eq_head_d    = eq_head_q;
    eq_tail_d    = push ? q_inc(eq_tail_q) : eq_tail_q;
    tlp_cnt_d    = tlp_cnt_q + CW'(push) - CW'(ack_take);
    unacked_d    = unacked_after + CW'(link_accept && link_last_q);
    timer_d      = (unacked_q == '0 || ack_i || nack_i || timeout_hit) ? '0 : timer_q + 1'b1;
    replay_cnt_d = replay_cnt_q;
    pend_d       = pend_q || nack_take || timeout_hit;
    mid_d        = mid_q;
    link_data_d  = link_data_q;
    link_valid_d = link_valid_q;
    link_last_d  = link_last_q;

    if (ack_take) begin
      ack_ptr_d = end_mem[eq_head_q];
      eq_head_d = q_inc(eq_head_q);
    end

    if (fetch) begin
      link_valid_d = 1'b1;
      link_data_d  = fetch_word[DATA_W-1:0];
      link_last_d  = fetch_word[DATA_W];
      rd_ptr_d     = rd_ptr_q + 1'b1;
      mid_d        = !fetch_word[DATA_W];
    end else if (link_accept) begin
      link_valid_d = 1'b0;
    end

    case (state_q)
      ST_SEND: begin
        if (pend_q && !mid_q && !link_valid_q) state_d = ST_REWIND;
      end
      ST_REWIND: begin
        rd_ptr_d     = ack_ptr_d;
        unacked_d    = '0;
        timer_d      = '0;
        pend_d       = 1'b0;
        mid_d        = 1'b0;
        replay_cnt_d = replay_nxt;
        state_d      = (replay_nxt >= RW'(REPLAY_MAX)) ? ST_ERROR : ST_SEND;
      end
      default: begin
        link_valid_d = 1'b0;
        pend_d       = 1'b0;
      end
    endcase

    if (ack_take) replay_cnt_d = '0;
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SEND;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ack_ptr_q    <= '0;
      eq_head_q    <= '0;
      eq_tail_q    <= '0;
      tlp_cnt_q    <= '0;
      unacked_q    <= '0;
      timer_q      <= '0;
      replay_cnt_q <= '0;
      pend_q       <= 1'b0;
      mid_q        <= 1'b0;
      link_data_q  <= '0;
      link_valid_q <= 1'b0;
      link_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ack_ptr_q    <= ack_ptr_d;
      eq_head_q    <= eq_head_d;
      eq_tail_q    <= eq_tail_d;
      tlp_cnt_q    <= tlp_cnt_d;
      unacked_q    <= unacked_d;
      timer_q      <= timer_d;
      replay_cnt_q <= replay_cnt_d;
      pend_q       <= pend_d;
      mid_q        <= mid_d;
      link_data_q  <= link_data_d;
      link_valid_q <= link_valid_d;
      link_last_q  <= link_last_d;
    end
  end

  // NOTE: storage arrays are not reset; pointers alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {tlp_last_i, tlp_data_i};
    if (push)  end_mem[eq_tail_q]    <= wr_ptr_q + 1'b1;
  end

  assign link_data_o  = link_data_q;
  assign link_valid_o = link_valid_q;
  assign link_last_o  = link_last_q;
  assign unacked_o    = unacked_q;
  assign replay_o     = (state_q == ST_REWIND);
  assign link_err_o   = (state_q == ST_ERROR);

endmodule

// File: tb/tb_pcie_dll_replay_tx.sv
// Directed self-checking bench for pcie_dll_replay_tx: in-order delivery, ack/nack/timeout replay,
// buffer-full back-pressure, replay-limit error and reset mid-replay.
module tb_pcie_dll_replay_tx;

  localparam int DW   = 32;
  localparam int DEP  = 64;
  localparam int MAXT = 16;
  localparam int TO   = 1024;
  localparam int RMAX = 4;
  localparam int CW   = $clog2(MAXT + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] tlp_data_i = '0;
  logic          tlp_valid_i = 1'b0;
  logic          tlp_last_i = 1'b0;
  logic          tlp_ready_o;
  logic [DW-1:0] link_data_o;
  logic          link_valid_o;
  logic          link_last_o;
  logic          link_ready_i = 1'b1;
  logic          ack_i = 1'b0;
  logic          nack_i = 1'b0;
  logic [CW-1:0] unacked_o;
  logic          replay_o;
  logic          link_err_o;

  pcie_dll_replay_tx #(
    .DATA_W(DW), .DEPTH(DEP), .MAX_TLP(MAXT), .TIMEOUT(TO), .REPLAY_MAX(RMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .tlp_data_i(tlp_data_i), .tlp_valid_i(tlp_valid_i), .tlp_last_i(tlp_last_i),
    .tlp_ready_o(tlp_ready_o),
    .link_data_o(link_data_o), .link_valid_o(link_valid_o), .link_last_o(link_last_o),
    .link_ready_i(link_ready_i),
    .ack_i(ack_i), .nack_i(nack_i),
    .unacked_o(unacked_o), .replay_o(replay_o), .link_err_o(link_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int stalls = 0;
  int replay_seen = 0;
  int cyc = 0;
  bit bp_en = 1'b0;
  logic [DW:0] got_q[$];
  logic [DW:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Link-side monitor samples mid-cycle; the handshake completes on the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (link_valid_o && link_ready_i) got_q.push_back({link_last_o, link_data_o});
      if (replay_o) replay_seen++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      link_ready_i = !bp_en || (cyc % 3 != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic l);
    int b = 0;
    tlp_valid_i = 1'b1;
    tlp_data_i  = d;
    tlp_last_i  = l;
    while (!tlp_ready_o && b < 3000) begin
      stalls++;
      step();
      b++;
    end
    check("push_ready", tlp_ready_o, 1'b1);
    step();
    tlp_valid_i = 1'b0;
    tlp_last_i  = 1'b0;
  endtask

  function automatic logic [DW-1:0] word_of(input int id, input int w);
    return DW'((id << 8) | w);
  endfunction

  task automatic send_tlp(input int id, input int n);
    for (int w = 0; w < n; w++) push_word(word_of(id, w), w == n - 1);
  endtask

  task automatic add_exp(input int id, input int n);
    for (int w = 0; w < n; w++) exp_q.push_back({w == n - 1, word_of(id, w)});
  endtask

  task automatic wait_words(input int n);
    int b = 0;
    while (got_q.size() < n && b < 4000) begin
      step();
      b++;
    end
  endtask

  task automatic wait_replay(input int target, input int budget);
    int b = 0;
    while (replay_seen < target && b < budget) begin
      step();
      b++;
    end
    check("replay_count", replay_seen, target);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_ack();
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
  endtask

  task automatic pulse_nack();
    nack_i = 1'b1;
    step();
    nack_i = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tlp_ready"},  tlp_ready_o, 1'b1);
    check({tag, "_link_valid"}, link_valid_o, 1'b0);
    check({tag, "_link_last"},  link_last_o, 1'b0);
    check({tag, "_link_data"},  link_data_o, '0);
    check({tag, "_unacked"},    unacked_o, '0);
    check({tag, "_replay"},     replay_o, 1'b0);
    check({tag, "_link_err"},   link_err_o, 1'b0);
  endtask

  initial begin
    int r0;
    int n;
    int b;

    idle(3);
    check_reset("rst0");
    rst = 1'b0;
    step();

    // 1) three 4-word TLPs with link back-pressure, then three acks
    bp_en  = 1'b1;
    stalls = 0;
    for (int t = 0; t < 3; t++) begin
      send_tlp(t, 4);
      add_exp(t, 4);
    end
    wait_words(12);
    bp_en = 1'b0;
    idle(4);
    compare_stream("t1");
    check("t1_unacked", unacked_o, 3);
    check("t1_no_stall", stalls, 0);
    for (int k = 0; k < 3; k++) begin
      pulse_ack();
      check($sformatf("t1_ack%0d_unacked", k), unacked_o, 2 - k);
    end

    // 2) nack with two unacked TLPs replays both
    send_tlp(4, 4);
    send_tlp(5, 4);
    wait_words(8);
    idle(4);
    check("t2_unacked", unacked_o, 2);
    r0 = replay_seen;
    pulse_nack();
    wait_replay(r0 + 1, 50);
    add_exp(4, 4); add_exp(5, 4); add_exp(4, 4); add_exp(5, 4);
    wait_words(16);
    idle(4);
    compare_stream("t2");
    check("t2_unacked_resent", unacked_o, 2);
    pulse_ack();
    pulse_ack();
    check("t2_unacked_final", unacked_o, 0);

    // 3) nack arriving mid third TLP: TLP finishes, then all three are resent
    send_tlp(6, 4);
    send_tlp(7, 4);
    wait_words(8);
    idle(2);
    r0 = replay_seen;
    push_word(word_of(8, 0), 1'b0);
    push_word(word_of(8, 1), 1'b0);
    pulse_nack();
    push_word(word_of(8, 2), 1'b0);
    push_word(word_of(8, 3), 1'b1);
    wait_replay(r0 + 1, 50);
    add_exp(6, 4); add_exp(7, 4); add_exp(8, 4);
    add_exp(6, 4); add_exp(7, 4); add_exp(8, 4);
    wait_words(24);
    idle(4);
    compare_stream("t3");
    check("t3_unacked", unacked_o, 3);
    repeat (3) pulse_ack();
    check("t3_unacked_final", unacked_o, 0);

    // 4) fill the whole buffer (straddling the address wrap), then free one TLP
    stalls = 0;
    for (int t = 16; t < 32; t++) begin
      send_tlp(t, 4);
      add_exp(t, 4);
    end
    check("t4_no_stall", stalls, 0);
    check("t4_full_ready", tlp_ready_o, 1'b0);
    wait_words(64);
    idle(4);
    check("t4_unacked", unacked_o, 16);
    check("t4_still_full", tlp_ready_o, 1'b0);
    pulse_ack();
    check("t4_ready_after_ack", tlp_ready_o, 1'b1);
    compare_stream("t4");
    repeat (15) pulse_ack();
    check("t4_unacked_final", unacked_o, 0);

    // 5) no ack: timeout replays until the replay limit trips the error state
    r0 = replay_seen;
    send_tlp(40, 4);
    b = 0;
    while (unacked_o != 1 && b < 100) begin
      step();
      b++;
    end
    check("t5_unacked", unacked_o, 1);
    n = 0;
    while (!replay_o && n < 2000) begin
      step();
      n++;
    end
    check("t5_timeout_window", (n >= TO) && (n <= TO + 8), 1'b1);
    wait_replay(r0 + 4, 5000);
    b = 0;
    while (!link_err_o && b < 50) begin
      step();
      b++;
    end
    check("t5_link_err", link_err_o, 1'b1);
    check("t5_link_valid", link_valid_o, 1'b0);
    check("t5_tlp_ready", tlp_ready_o, 1'b0);
    idle(4);
    check("t5_err_sticky", link_err_o, 1'b1);
    for (int k = 0; k < 4; k++) add_exp(40, 4);
    compare_stream("t5");

    // 6) reset clears the error state; same-cycle ack+nack replays only the second TLP
    rst = 1'b1;
    step();
    check_reset("rst1");
    rst = 1'b0;
    step();
    send_tlp(50, 4);
    send_tlp(51, 4);
    wait_words(8);
    idle(2);
    check("t6_unacked", unacked_o, 2);
    r0 = replay_seen;
    ack_i  = 1'b1;
    nack_i = 1'b1;
    step();
    ack_i  = 1'b0;
    nack_i = 1'b0;
    check("t6_unacked_after_ack", unacked_o, 1);
    wait_replay(r0 + 1, 50);
    add_exp(50, 4); add_exp(51, 4); add_exp(51, 4);
    wait_words(12);
    idle(4);
    compare_stream("t6");
    check("t6_unacked_resent", unacked_o, 1);

    r0 = replay_seen;
    pulse_nack();
    wait_replay(r0 + 1, 50);
    idle(2);
    rst = 1'b1;
    got_q.delete();
    #1;
    check_reset("rst_mid");
    step();
    rst = 1'b0;
    idle(20);
    check("t6_no_words_after_rst", got_q.size(), 0);
    check("t6_ready_after_rst", tlp_ready_o, 1'b1);
    check("t6_unacked_after_rst", unacked_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
